encoder_position: RTL

- Downstream consumer of the quadrature `encoder` block's one-cycle `o_Left`/`o_Right` pulses.
- Keeps a bounded position value: right pulse increments, left pulse decrements.
- Converts the value to packed BCD with a sequential double-dabble engine.
- The BCD output feeds the TM1638 display driver.

---
 rtl/encoder_position.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/encoder_position.sv
// Bounded up/down position counter fed by encoder step pulses, with a sequential double-dabble BCD converter.
// Optional step acceleration is compiled in when ENCODER_ACCEL_EN is defined.
module encoder_position #(
  parameter int WIDTH        = 8,
  parameter int MIN_VAL      = 0,
  parameter int MAX_VAL      = 99,
  parameter int RESET_VAL    = 0,
  parameter int WRAP         = 1,
  parameter int DIGITS       = 3,
  parameter int ACCEL_WINDOW = 20
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_n,
  input  logic                  i_Left,
  input  logic                  i_Right,
  input  logic                  i_Load,
  input  logic [WIDTH-1:0]      i_Load_Val,
  output logic [WIDTH-1:0]      o_Value,
  output logic                  o_Changed,
  output logic [4*DIGITS-1:0]   o_Bcd,
  output logic                  o_Bcd_Valid,
  output logic                  o_Busy
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [WIDTH:0]     MIN_W    = (WIDTH + 1)'(MIN_VAL);
  localparam logic [WIDTH:0]     MAX_W    = (WIDTH + 1)'(MAX_VAL);
  localparam logic [WIDTH:0]     MAXP1_W  = (WIDTH + 1)'(MAX_VAL + 1);
  localparam logic [WIDTH:0]     RST_W    = (WIDTH + 1)'(RESET_VAL);
  localparam logic [WIDTH:0]     ONE_W    = (WIDTH + 1)'(1);
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(WIDTH - 1);

  if (MAX_VAL >= 10 ** DIGITS) begin : g_digits_chk
    $fatal(1, "encoder_position: MAX_VAL does not fit in DIGITS BCD digits");
  end
  if (MIN_VAL > RESET_VAL || RESET_VAL > MAX_VAL || ACCEL_WINDOW < 1) begin : g_range_chk
    $fatal(1, "encoder_position: inconsistent MIN_VAL/RESET_VAL/MAX_VAL/ACCEL_WINDOW");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  logic [WIDTH-1:0] value_q, value_d;
  logic             changed_q, changed_d;
  logic [WIDTH:0]   step_w;
  logic [WIDTH:0]   cur_w, load_w, up_w, wrap_w;

  state_t           state_q, state_d;
  logic             pending_q, pending_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [BCD_W-1:0] scr_q, scr_d, adj;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic             vld_q, vld_d;
  logic             busy_q, busy_d;

`ifdef ENCODER_ACCEL_EN
  localparam int               TMR_W   = $clog2(ACCEL_WINDOW + 2);
  localparam logic [TMR_W-1:0] TMR_SAT = TMR_W'(ACCEL_WINDOW + 1);
  localparam logic [TMR_W-1:0] TMR_WIN = TMR_W'(ACCEL_WINDOW);
  localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);
  localparam logic [WIDTH:0]   FOUR_W  = (WIDTH + 1)'(4);

  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             dir_q, dir_d;

  // tmr_q holds clocks since the last accepted step; starts saturated so the first step is 1
  always_comb begin
    tmr_d  = (tmr_q == TMR_SAT) ? tmr_q : tmr_q + 1'b1;
    dir_d  = dir_q;
    step_w = ONE_W;
    if (!i_Load && (i_Left ^ i_Right)) begin
      if ((i_Right == dir_q) && (tmr_q <= TMR_WIN)) begin
        step_w = FOUR_W;
      end
      tmr_d = TMR_ONE;
      dir_d = i_Right;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      tmr_q <= TMR_SAT;
      dir_q <= 1'b0;
    end else begin
      tmr_q <= tmr_d;
      dir_q <= dir_d;
    end
  end
`else
  assign step_w = ONE_W;
`endif

  // Position update; one spare bit keeps limit checks free of binary wrap
  always_comb begin
    value_d = value_q;
    cur_w   = {1'b0, value_q};
    load_w  = {1'b0, i_Load_Val};
    up_w    = cur_w + step_w;
    wrap_w  = '0;
    if (i_Load) begin
      if (load_w < MIN_W) begin
        value_d = MIN_W[WIDTH-1:0];
      end else if (load_w > MAX_W) begin
        value_d = MAX_W[WIDTH-1:0];
      end else begin
        value_d = i_Load_Val;
      end
    end else if (i_Right && !i_Left) begin
      if (up_w > MAX_W) begin
        wrap_w  = up_w - MAXP1_W + MIN_W;
        value_d = (WRAP != 0) ? wrap_w[WIDTH-1:0] : MAX_W[WIDTH-1:0];
      end else begin
        value_d = up_w[WIDTH-1:0];
      end
    end else if (i_Left && !i_Right) begin
      if (cur_w < MIN_W + step_w) begin
        wrap_w  = MAXP1_W - (MIN_W + step_w - cur_w);
        value_d = (WRAP != 0) ? wrap_w[WIDTH-1:0] : MIN_W[WIDTH-1:0];
      end else begin
        wrap_w  = cur_w - step_w;
        value_d = wrap_w[WIDTH-1:0];
      end
    end
    changed_d = (value_d != value_q);
  end

  // Conversion FSM: a change during a conversion is remembered in pending_q
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q | changed_d;
    sr_d      = sr_q;
    scr_d     = scr_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    vld_d     = 1'b0;
    busy_d    = busy_q;

    adj = scr_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (pending_q) begin
          sr_d      = value_q;
          scr_d     = '0;
          cnt_d     = '0;
          pending_d = changed_d;
          busy_d    = 1'b1;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        {scr_d, sr_d} = {adj[BCD_W-2:0], sr_q, 1'b0};
        cnt_d         = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        bcd_d   = scr_q;
        vld_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      value_q   <= RST_W[WIDTH-1:0];
      changed_q <= 1'b0;
      state_q   <= S_IDLE;
      pending_q <= 1'b1;
      sr_q      <= '0;
      scr_q     <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      vld_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      value_q   <= value_d;
      changed_q <= changed_d;
      state_q   <= state_d;
      pending_q <= pending_d;
      sr_q      <= sr_d;
      scr_q     <= scr_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      vld_q     <= vld_d;
      busy_q    <= busy_d;
    end
  end

  assign o_Value     = value_q;
  assign o_Changed   = changed_q;
  assign o_Bcd       = bcd_q;
  assign o_Bcd_Valid = vld_q;
  assign o_Busy      = busy_q;

endmodule
